// File: rtl/nx_ram_1rw_arb_if.sv
// Requester and RAM-pin bundle for nx_ram_1rw_arb.
// slave: the arbiter's view; master: the clients' and RAM's view.
interface nx_ram_1rw_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 96,
  parameter int AW      = 9
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_add;
  logic [NUM_REQ*WIDTH-1:0] req_din;
  logic [NUM_REQ*WIDTH-1:0] req_bwe;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_dout;
  logic                     ram_cs;
  logic                     ram_we;
  logic [AW-1:0]            ram_add;
  logic [WIDTH-1:0]         ram_din;
  logic [WIDTH-1:0]         ram_bwe;
  logic [WIDTH-1:0]         ram_dout;

  modport slave (
    input  req_valid, req_we, req_add, req_din, req_bwe, ram_dout,
    output req_ready, rsp_valid, rsp_dout, ram_cs, ram_we, ram_add, ram_din, ram_bwe
  );

  modport master (
    output req_valid, req_we, req_add, req_din, req_bwe, ram_dout,
    input  req_ready, rsp_valid, rsp_dout, ram_cs, ram_we, ram_add, ram_din, ram_bwe
  );
endinterface

// File: rtl/nx_ram_1rw_arb.sv
// Round-robin arbiter sharing one 1rw RAM (registered read) between NUM_REQ requesters.
// Optional NX_RAM_ARB_INIT_EN: zero-fill the whole RAM after reset before accepting traffic.
module nx_ram_1rw_arb #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 96,
  parameter int DEPTH   = 512,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nx_ram_1rw_arb_if.slave       bus,
  output logic                  init_done_o,
  output logic [31:0]           grant_cnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      rrPtr_q;
  logic [PW-1:0]      winner;
  logic               grant;
  logic [NUM_REQ-1:0] grantOneHot;
  logic [NUM_REQ-1:0] rspValid_q;
  logic               initDone_q;
  logic [31:0]        grantCnt_q;
  logic [AW-1:0]      lastAdd_q;
  logic [WIDTH-1:0]   lastDin_q;
  logic [WIDTH-1:0]   lastBwe_q;

`ifdef NX_RAM_ARB_INIT_EN
  localparam logic [AW:0] INIT_LAST = (AW+1)'(DEPTH - 1);
  logic [AW:0] initCnt_q;
`endif

  // Scan starts at the round-robin pointer; the first valid requester found wins.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant && bus.req_valid[(int'(rrPtr_q) + k) % NUM_REQ]) begin
          grant  = 1'b1;
          winner = PW'((int'(rrPtr_q) + k) % NUM_REQ);
        end
      end
    end
    grantOneHot = grant ? (NUM_REQ'(1) << winner) : '0;
  end

  always_comb begin
    bus.req_ready = grantOneHot;
    bus.rsp_valid = rspValid_q;
    bus.rsp_dout  = bus.ram_dout;
    bus.ram_cs    = grant;
    bus.ram_we    = grant & bus.req_we[winner];
    bus.ram_add   = grant ? bus.req_add[winner*AW +: AW]       : lastAdd_q;
    bus.ram_din   = grant ? bus.req_din[winner*WIDTH +: WIDTH] : lastDin_q;
    bus.ram_bwe   = grant ? bus.req_bwe[winner*WIDTH +: WIDTH] : lastBwe_q;
`ifdef NX_RAM_ARB_INIT_EN
    if (state_q == INIT) begin
      bus.ram_cs  = 1'b1;
      bus.ram_we  = 1'b1;
      bus.ram_add = initCnt_q[AW-1:0];
      bus.ram_din = '0;
      bus.ram_bwe = '1;
    end
`endif
  end

  assign init_done_o = initDone_q;
  assign grant_cnt_o = grantCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      rspValid_q <= '0;
      initDone_q <= 1'b0;
      grantCnt_q <= '0;
      lastAdd_q  <= '0;
      lastDin_q  <= '0;
      lastBwe_q  <= '0;
`ifdef NX_RAM_ARB_INIT_EN
      initCnt_q  <= '0;
`endif
    end else begin
      lastAdd_q  <= bus.ram_add;
      lastDin_q  <= bus.ram_din;
      lastBwe_q  <= bus.ram_bwe;
      rspValid_q <= (grant && !bus.req_we[winner]) ? grantOneHot : '0;

      if (grant) begin
        rrPtr_q <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        if (grantCnt_q != 32'hFFFF_FFFF) begin
          grantCnt_q <= grantCnt_q + 32'd1;
        end
      end

      case (state_q)
        IDLE: begin
`ifdef NX_RAM_ARB_INIT_EN
          state_q   <= INIT;
          initCnt_q <= '0;
`else
          state_q    <= RUN;
          initDone_q <= 1'b1;
`endif
        end
`ifdef NX_RAM_ARB_INIT_EN
        INIT: begin
          initCnt_q <= initCnt_q + 1'b1;
          if (initCnt_q == INIT_LAST) begin
            state_q    <= RUN;
            initDone_q <= 1'b1;
          end
        end
`endif
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nx_ram_1rw_arb.sv
// Directed self-checking bench for nx_ram_1rw_arb with a behavioural 1rw RAM attached.
module tb_nx_ram_1rw_arb;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 96;
  localparam int DEPTH   = 512;
  localparam int AW      = 9;
  localparam logic [WIDTH-1:0] ONES = '1;
`ifdef NX_RAM_ARB_INIT_EN
  localparam int INIT_CYCLES = DEPTH + 1;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        initDone;
  logic [31:0] grantCnt;
  int          checkCount = 0;
  int          errCount = 0;
  int          expGrants = 0;

  always #5 clk = ~clk;

  nx_ram_1rw_arb_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  nx_ram_1rw_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_done_o (initDone),
    .grant_cnt_o (grantCnt)
  );

  // Behavioural single-port RAM: bit-masked write, registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ramDout;
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we)
        mem[bus.ram_add] <= (mem[bus.ram_add] & ~bus.ram_bwe) | (bus.ram_din & bus.ram_bwe);
      else
        ramDout <= mem[bus.ram_add];
    end
  end
  assign bus.ram_dout = ramDout;

`ifdef NX_RAM_ARB_INIT_EN
  int initNext = 0;
  int initBad = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initNext = 0;
      initBad  = 0;
    end else if (bus.ram_cs && bus.ram_we && !initDone) begin
      if (int'(bus.ram_add) == initNext && bus.ram_din == '0 && bus.ram_bwe == ONES)
        initNext++;
      else
        initBad++;
    end
  end
`endif

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                               input logic [AW-1:0] add0, input logic [AW-1:0] add1,
                               input logic [WIDTH-1:0] din0, input logic [WIDTH-1:0] din1,
                               input logic [WIDTH-1:0] bwe);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_add   = {add1, add0};
    bus.req_din   = {din1, din0};
    bus.req_bwe   = {bwe, bwe};
  endtask

  task automatic waitInit();
    int cyc;
    cyc = 0;
    while (!initDone && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("init_cycle", cyc, INIT_CYCLES);
  endtask

  initial begin
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_init_done", initDone, 0);
    checkOutput("reset_ram_cs", bus.ram_cs, 0);
    checkOutput("reset_ram_add", bus.ram_add, 0);
    checkOutput("reset_grant_cnt", grantCnt, 0);
    rst_n = 1'b1;
    waitInit();

`ifdef NX_RAM_ARB_INIT_EN
    checkOutput("init_writes", initNext, DEPTH);
    checkOutput("init_bad_writes", initBad, 0);
    applyStimulus(2'b01, 2'b00, 9'd511, '0, '0, '0, ONES);
    #1 checkOutput("init_rd_ready", bus.req_ready, 2'b01);
    expGrants++;
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    checkOutput("init_rd_valid", bus.rsp_valid, 2'b01);
    checkOutput("init_rd_dout", bus.rsp_dout, 0);
`endif

    checkOutput("idle_ready", bus.req_ready, 0);
    checkOutput("idle_ram_cs", bus.ram_cs, 0);

    // Write then read the same address from requester 0.
    @(negedge clk);
    applyStimulus(2'b01, 2'b01, 9'd10, 9'd7, 96'hA5, 96'h77, ONES);
    #1;
    checkOutput("wr_ready", bus.req_ready, 2'b01);
    checkOutput("wr_cs", bus.ram_cs, 1);
    checkOutput("wr_we", bus.ram_we, 1);
    checkOutput("wr_add", bus.ram_add, 10);
    checkOutput("wr_din", bus.ram_din, 96'hA5);
    expGrants++;
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 9'd10, 9'd7, '0, '0, ONES);
    #1;
    checkOutput("rd_ready", bus.req_ready, 2'b01);
    checkOutput("rd_we", bus.ram_we, 0);
    checkOutput("wr_no_rsp", bus.rsp_valid, 0);
    expGrants++;
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    checkOutput("rd_rsp_valid", bus.rsp_valid, 2'b01);
    checkOutput("rd_rsp_dout", bus.rsp_dout, 96'hA5);
    checkOutput("rd_grant_cnt", grantCnt, expGrants);
    #1;
    checkOutput("nogrant_cs", bus.ram_cs, 0);
    checkOutput("nogrant_add_hold", bus.ram_add, 10);
    @(negedge clk);
    checkOutput("rsp_one_cycle", bus.rsp_valid, 0);

    // Requester 1 clears address 3; also moves the pointer back to 0.
    applyStimulus(2'b10, 2'b10, 9'd20, 9'd3, 96'h1234, '0, ONES);
    #1;
    checkOutput("r1wr_ready", bus.req_ready, 2'b10);
    checkOutput("r1wr_add", bus.ram_add, 3);
    checkOutput("r1wr_din", bus.ram_din, 0);
    expGrants++;

    // Both requesters contend with reads: grants must alternate starting at 0.
    begin
      logic [1:0] prevExp;
      logic [1:0] curExp;
      prevExp = 2'b00;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i > 0) begin
          checkOutput("rr_rsp_valid", bus.rsp_valid, prevExp);
          checkOutput("rr_rsp_dout", bus.rsp_dout, (prevExp == 2'b01) ? 96'hA5 : 96'h0);
        end
        applyStimulus(2'b11, 2'b00, 9'd10, 9'd3, '0, '0, ONES);
        curExp = (i % 2 == 0) ? 2'b01 : 2'b10;
        #1;
        checkOutput("rr_ready", bus.req_ready, curExp);
        checkOutput("rr_add", bus.ram_add, (curExp == 2'b01) ? 10 : 3);
        prevExp = curExp;
        expGrants++;
      end
      @(negedge clk);
      applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
      checkOutput("rr_rsp_valid_last", bus.rsp_valid, prevExp);
      checkOutput("rr_rsp_dout_last", bus.rsp_dout, 96'h0);
    end

    // Partial write over zeroed word, read back by the other requester.
    @(negedge clk);
    applyStimulus(2'b01, 2'b01, 9'd3, 9'd0, 96'hFF, '0, 96'h0F);
    #1;
    checkOutput("pw_ready", bus.req_ready, 2'b01);
    checkOutput("pw_bwe", bus.ram_bwe, 96'h0F);
    expGrants++;
    @(negedge clk);
    applyStimulus(2'b10, 2'b00, 9'd0, 9'd3, '0, '0, ONES);
    #1 checkOutput("pr_ready", bus.req_ready, 2'b10);
    expGrants++;
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    checkOutput("pr_rsp_valid", bus.rsp_valid, 2'b10);
    checkOutput("pr_rsp_dout", bus.rsp_dout, 96'h0F);
    checkOutput("pr_grant_cnt", grantCnt, expGrants);

    // Reset in the cycle after a read grant drops the pending response.
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 9'd10, 9'd0, '0, '0, ONES);
    #1 checkOutput("pre_rst_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_init_done", initDone, 0);
    checkOutput("rst_grant_cnt", grantCnt, 0);
    checkOutput("rst_ram_cs", bus.ram_cs, 0);
    @(negedge clk);
    checkOutput("rst_rsp_hold", bus.rsp_valid, 0);
    rst_n = 1'b1;
    waitInit();
    applyStimulus(2'b11, 2'b00, 9'd10, 9'd3, '0, '0, ONES);
    #1 checkOutput("post_rst_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0);
    checkOutput("post_rst_rsp", bus.rsp_valid, 2'b01);
    checkOutput("post_rst_grant_cnt", grantCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
